// File: rtl/aes_block_sequencer_if.sv
// Purpose: stream and AES-core handshake bundle for aes_block_sequencer.
//   in_*   : input word stream (valid/ready), driven by the source
//   out_*  : output word stream (valid/ready), consumed by the sink
//   core_* : block hand-off to and result return from the external AES round core
//   master : the sequencer side; slave : the environment (streamers + core)
interface aes_block_sequencer_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BLOCK_W = 128
);
  logic [DATA_W-1:0]  in_data_i;
  logic               in_valid_i;
  logic               in_ready_o;
  logic [DATA_W-1:0]  out_data_o;
  logic               out_valid_o;
  logic               out_ready_i;
  logic               core_start_o;
  logic [BLOCK_W-1:0] core_block_o;
  logic [1:0]         core_key_size_o;
  logic               core_done_i;
  logic [BLOCK_W-1:0] core_block_i;

  modport master (
    input  in_data_i, in_valid_i, out_ready_i, core_done_i, core_block_i,
    output in_ready_o, out_data_o, out_valid_o, core_start_o, core_block_o, core_key_size_o
  );

  modport slave (
    output in_data_i, in_valid_i, out_ready_i, core_done_i, core_block_i,
    input  in_ready_o, out_data_o, out_valid_o, core_start_o, core_block_o, core_key_size_o
  );
endinterface

// File: rtl/aes_block_sequencer.sv
// Purpose: splits a job of data_size_i bytes into 128-bit blocks, feeds them to an external
//   AES round core and streams the results out, with ECB / CBC-encrypt / CTR chaining.
// Ports:
//   clk_i, rst_ni   clock, synchronous active-low reset
//   clear_i         synchronous soft clear (same effect as reset, wins over everything)
//   start_i         job start, sampled only in IDLE
//   data_size_i     job length in bytes (rounded up to whole blocks)
//   key_size_i      key mode, forwarded to the core
//   mode_i          00 ECB, 01 CBC-enc, 10 CTR, 11 ECB
//   iv_i            CBC IV / CTR initial counter
//   bus             streams + core handshake (master modport)
//   busy_o          job in progress
//   done_o          one-cycle end-of-job pulse
//   block_cnt_o     blocks fully emitted in the current job
module aes_block_sequencer #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned BLOCK_W = 128,
  parameter int unsigned CTR_W   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  start_i,
  input  logic [31:0]           data_size_i,
  input  logic [1:0]            key_size_i,
  input  logic [1:0]            mode_i,
  input  logic [BLOCK_W-1:0]    iv_i,
  aes_block_sequencer_if.master bus,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [31:0]           block_cnt_o
);

  localparam int unsigned NB_WORDS = BLOCK_W / DATA_W;
  localparam int unsigned CNT_W    = (NB_WORDS > 1) ? $clog2(NB_WORDS) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NB_WORDS - 1);
  localparam logic [BLOCK_W-1:0] CTR_MASK =
    (CTR_W >= BLOCK_W) ? {BLOCK_W{1'b1}} : ((BLOCK_W'(1) << CTR_W) - BLOCK_W'(1));
  localparam logic [1:0] MODE_CBC = 2'b01;
  localparam logic [1:0] MODE_CTR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CORE,
    ST_SEND,
    ST_FINISHED
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic [1:0]         key_q, key_d;
  logic [32:0]        blk_left_q, blk_left_d;
  logic [31:0]        block_cnt_q, block_cnt_d;
  logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [BLOCK_W-1:0] in_blk_q, in_blk_d;
  logic [BLOCK_W-1:0] out_blk_q, out_blk_d;
  logic [BLOCK_W-1:0] chain_q, chain_d;
  logic [BLOCK_W-1:0] ctr_q, ctr_d;
  logic [BLOCK_W-1:0] core_block_q, core_block_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               core_start_q, core_start_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [32:0]        nblk_c;
  logic [BLOCK_W-1:0] in_shift_c;

  // Block count rounded up, in 33 bits so a full 32-bit size cannot wrap.
  assign nblk_c     = (33'(data_size_i) + 33'd15) >> 4;
  // Words arrive MSB first, so each new word shifts in at the bottom.
  assign in_shift_c = (in_blk_q << DATA_W) | BLOCK_W'(bus.in_data_i);

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    key_d        = key_q;
    blk_left_d   = blk_left_q;
    block_cnt_d  = block_cnt_q;
    word_cnt_d   = word_cnt_q;
    in_blk_d     = in_blk_q;
    out_blk_d    = out_blk_q;
    chain_d      = chain_q;
    ctr_d        = ctr_q;
    core_block_d = core_block_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mode_d      = mode_i;
          key_d       = key_size_i;
          blk_left_d  = nblk_c;
          block_cnt_d = '0;
          word_cnt_d  = '0;
          chain_d     = iv_i;
          ctr_d       = iv_i;
          state_d     = (nblk_c == 33'd0) ? ST_FINISHED : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (bus.in_valid_i && in_ready_q) begin
          in_blk_d = in_shift_c;
          if (word_cnt_q == LAST_WORD) begin
            word_cnt_d = '0;
            state_d    = ST_CORE;
            if (mode_q == MODE_CTR)      core_block_d = ctr_q;
            else if (mode_q == MODE_CBC) core_block_d = in_shift_c ^ chain_q;
            else                         core_block_d = in_shift_c;
          end else begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_CORE: begin
        // A done coincident with our own start pulse cannot be ours; ignore it.
        if (!core_start_q && bus.core_done_i) begin
          state_d = ST_SEND;
          if (mode_q == MODE_CTR) begin
            out_blk_d = in_blk_q ^ bus.core_block_i;
            ctr_d     = (ctr_q & ~CTR_MASK) | ((ctr_q + BLOCK_W'(1)) & CTR_MASK);
          end else begin
            out_blk_d = bus.core_block_i;
          end
          if (mode_q == MODE_CBC) chain_d = bus.core_block_i;
        end
      end
      ST_SEND: begin
        if (out_valid_q && bus.out_ready_i) begin
          out_blk_d = out_blk_q << DATA_W;
          if (word_cnt_q == LAST_WORD) begin
            word_cnt_d  = '0;
            block_cnt_d = block_cnt_q + 32'd1;
            blk_left_d  = blk_left_q - 33'd1;
            state_d     = (blk_left_q == 33'd1) ? ST_FINISHED : ST_LOAD;
          end else begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
          end
        end
      end
      ST_FINISHED: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they are flops aligned with state_q.
    in_ready_d   = (state_d == ST_LOAD);
    out_valid_d  = (state_d == ST_SEND);
    out_data_d   = (state_d == ST_SEND) ? out_blk_d[BLOCK_W-1 -: DATA_W] : '0;
    core_start_d = (state_d == ST_CORE) && (state_q != ST_CORE);
    done_d       = (state_d == ST_FINISHED);
    // Busy also covers the cycle leaving FINISHED so an empty job shows two busy cycles.
    busy_d       = (state_d != ST_IDLE) || (state_q != ST_IDLE);
  end

  // State and output registers; clear behaves exactly like reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      state_q      <= ST_IDLE;
      mode_q       <= '0;
      key_q        <= '0;
      blk_left_q   <= '0;
      block_cnt_q  <= '0;
      word_cnt_q   <= '0;
      in_blk_q     <= '0;
      out_blk_q    <= '0;
      chain_q      <= '0;
      ctr_q        <= '0;
      core_block_q <= '0;
      out_data_q   <= '0;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      core_start_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      key_q        <= key_d;
      blk_left_q   <= blk_left_d;
      block_cnt_q  <= block_cnt_d;
      word_cnt_q   <= word_cnt_d;
      in_blk_q     <= in_blk_d;
      out_blk_q    <= out_blk_d;
      chain_q      <= chain_d;
      ctr_q        <= ctr_d;
      core_block_q <= core_block_d;
      out_data_q   <= out_data_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.in_ready_o      = in_ready_q;
  assign bus.out_valid_o     = out_valid_q;
  assign bus.out_data_o      = out_data_q;
  assign bus.core_start_o    = core_start_q;
  assign bus.core_block_o    = core_block_q;
  assign bus.core_key_size_o = key_q;
  assign busy_o              = busy_q;
  assign done_o              = done_q;
  assign block_cnt_o         = block_cnt_q;

endmodule

// File: tb/tb_aes_block_sequencer.sv
// Bench for aes_block_sequencer: directed jobs, scoreboard of expected output words and
// core blocks, model core returning block ^ all-ones three cycles after core_start.
module tb_aes_block_sequencer;
  localparam int unsigned DATA_W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         clear;
  logic         start;
  logic [31:0]  data_size;
  logic [1:0]   key_size;
  logic [1:0]   mode;
  logic [127:0] iv;
  logic         busy;
  logic         done;
  logic [31:0]  block_cnt;

  always #5 clk = ~clk;

  aes_block_sequencer_if #(.DATA_W(DATA_W), .BLOCK_W(128)) bus ();

  aes_block_sequencer #(.DATA_W(DATA_W), .BLOCK_W(128), .CTR_W(32)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .clear_i    (clear),
    .start_i    (start),
    .data_size_i(data_size),
    .key_size_i (key_size),
    .mode_i     (mode),
    .iv_i       (iv),
    .bus        (bus),
    .busy_o     (busy),
    .done_o     (done),
    .block_cnt_o(block_cnt)
  );

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0]  exp_q[$];
  logic [127:0] core_q[$];

  int in_hs = 0, out_hs = 0, busy_cnt = 0, done_cnt = 0, cs_cnt = 0;
  int stall_cnt = 0, stab_err = 0, excl_err = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: timed out waiting at %0t", name, $time);
  endtask

  function automatic void push_blk(input logic [127:0] b);
    for (int i = 0; i < 4; i++) exp_q.push_back(b[127-32*i -: 32]);
  endfunction

  // Model AES core: result = block ^ all-ones, done pulse three cycles after start.
  logic [1:0]   pipe    = '0;
  logic [127:0] blk_lat = '0;
  always @(posedge clk) begin
    pipe <= {pipe[0], bus.core_start_o};
    if (bus.core_start_o) blk_lat <= bus.core_block_o;
    bus.core_done_i  <= pipe[1];
    bus.core_block_i <= blk_lat ^ {128{1'b1}};
  end

  // Monitor: scoreboard pops on output handshakes and core starts, plus event counters.
  always @(negedge clk) begin
    if (bus.out_valid_o && bus.out_ready_i) begin
      out_hs++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL out_word: unexpected word %h", bus.out_data_o);
      end else begin
        check("out_word", 128'(bus.out_data_o), 128'(exp_q.pop_front()));
      end
    end
    if (bus.core_start_o) begin
      cs_cnt++;
      if (core_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL core_block: unexpected start with %h", bus.core_block_o);
      end else begin
        check("core_block", bus.core_block_o, core_q.pop_front());
      end
    end
    if (bus.in_valid_i && bus.in_ready_o) in_hs++;
    if (busy) busy_cnt++;
    if (done) done_cnt++;
    if (bus.in_ready_o && bus.out_valid_o) excl_err++;
    if (prev_stall && (!bus.out_valid_o || bus.out_data_o !== prev_data)) stab_err++;
    if (bus.out_valid_o && !bus.out_ready_i) stall_cnt++;
    prev_stall = bus.out_valid_o && !bus.out_ready_i;
    prev_data  = bus.out_data_o;
  end

  task automatic start_job(input logic [1:0] m, input logic [127:0] v, input logic [31:0] sz,
                           input logic [1:0] ks);
    @(posedge clk); #1;
    mode = m; iv = v; data_size = sz; key_size = ks; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input logic [31:0] w[$]);
    foreach (w[i]) begin
      int n = 0;
      bus.in_data_i  = w[i];
      bus.in_valid_i = 1'b1;
      @(negedge clk);
      while (!bus.in_ready_o && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (!bus.in_ready_o) begin
        timeout("feed");
        bus.in_valid_i = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    bus.in_valid_i = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!done) timeout(name);
  endtask

  task automatic test1();
    logic [31:0] w[$];
    int d0;
    for (int i = 0; i < 8; i++) begin
      w.push_back(32'(i));
      exp_q.push_back(~32'(i));
    end
    core_q.push_back({32'd0, 32'd1, 32'd2, 32'd3});
    core_q.push_back({32'd4, 32'd5, 32'd6, 32'd7});
    d0 = done_cnt;
    start_job(2'b00, '0, 32'd32, 2'b00);
    feed(w);
    wait_done("t1_done");
    repeat (3) @(negedge clk);
    check("t1_block_cnt", 128'(block_cnt), 128'd2);
    check("t1_done_pulses", 128'(done_cnt - d0), 128'd1);
    check("t1_sb_empty", 128'(exp_q.size()), 128'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0]  w[$];
    logic [127:0] ctr_iv;
    int d0, b0, i0, o0, c0, s0, n;

    rst_n = 1'b0; clear = 1'b0; start = 1'b0; data_size = '0; key_size = '0;
    mode = '0; iv = '0;
    bus.in_data_i = '0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_done", 128'(done), 128'd0);
    check("rst_in_ready", 128'(bus.in_ready_o), 128'd0);
    check("rst_out_valid", 128'(bus.out_valid_o), 128'd0);
    check("rst_core_start", 128'(bus.core_start_o), 128'd0);
    check("rst_block_cnt", 128'(block_cnt), 128'd0);
    check("rst_out_data", 128'(bus.out_data_o), 128'd0);
    check("rst_core_block", bus.core_block_o, 128'd0);

    // 1: ECB, two blocks
    test1();

    // 2: CBC with iv=1, zero input
    core_q.push_back(128'h1);
    core_q.push_back(~128'h1);
    push_blk(~128'h1);
    push_blk(128'h1);
    w = {};
    for (int i = 0; i < 8; i++) w.push_back(32'h0);
    start_job(2'b01, 128'h1, 32'd32, 2'b10);
    check("t2_key_size", 128'(bus.core_key_size_o), 128'd2);
    feed(w);
    wait_done("t2_done");
    @(negedge clk);
    check("t2_block_cnt", 128'(block_cnt), 128'd2);

    // 3: CTR with low counter word about to wrap
    ctr_iv = {32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hFFFF_FFFF};
    core_q.push_back(ctr_iv);
    core_q.push_back({32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'h0000_0000});
    push_blk({32'h5A5A_5A5A, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 32'h0000_0000});
    push_blk({32'h5A5A_5A5A, 32'h5A5A_5A5A, 32'h5A5A_5A5A, 32'hFFFF_FFFF});
    start_job(2'b10, ctr_iv, 32'd32, 2'b00);
    feed(w);
    wait_done("t3_done");
    @(negedge clk);
    check("t3_block_cnt", 128'(block_cnt), 128'd2);

    // 4: empty job
    repeat (2) @(negedge clk);
    d0 = done_cnt; b0 = busy_cnt; i0 = in_hs; o0 = out_hs; c0 = cs_cnt;
    start_job(2'b00, '0, 32'd0, 2'b00);
    wait_done("t4_done");
    repeat (4) @(negedge clk);
    check("t4_busy_cycles", 128'(busy_cnt - b0), 128'd2);
    check("t4_done_pulses", 128'(done_cnt - d0), 128'd1);
    check("t4_in_hs", 128'(in_hs - i0), 128'd0);
    check("t4_out_hs", 128'(out_hs - o0), 128'd0);
    check("t4_core_starts", 128'(cs_cnt - c0), 128'd0);
    check("t4_block_cnt", 128'(block_cnt), 128'd0);

    // 5: output back-pressure, one block, size rounded up from 13 bytes
    w = {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'h0F0F_0F0F};
    core_q.push_back({32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'h0F0F_0F0F});
    push_blk(~{32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'h0F0F_0F0F});
    bus.out_ready_i = 1'b0;
    s0 = stall_cnt;
    start_job(2'b11, '0, 32'd13, 2'b01);
    feed(w);
    n = 0;
    while (!bus.out_valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid_o) timeout("t5_out_valid");
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    bus.out_ready_i = 1'b1;
    wait_done("t5_done");
    @(negedge clk);
    check("t5_stall_cycles", 128'(stall_cnt - s0), 128'd6);
    check("t5_block_cnt", 128'(block_cnt), 128'd1);
    check("t5_sb_empty", 128'(exp_q.size()), 128'd0);

    // 6: clear while the core is working
    w = {32'd0, 32'd1, 32'd2, 32'd3};
    core_q.push_back({32'd0, 32'd1, 32'd2, 32'd3});
    d0 = done_cnt; o0 = out_hs;
    start_job(2'b00, '0, 32'd32, 2'b00);
    feed(w);
    n = 0;
    while (!bus.core_start_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.core_start_o) timeout("t6_core_start");
    @(posedge clk); #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    repeat (6) @(negedge clk);
    check("t6_busy", 128'(busy), 128'd0);
    check("t6_in_ready", 128'(bus.in_ready_o), 128'd0);
    check("t6_block_cnt", 128'(block_cnt), 128'd0);
    check("t6_done_pulses", 128'(done_cnt - d0), 128'd0);
    check("t6_out_hs", 128'(out_hs - o0), 128'd0);
    test1();

    check("handshake_exclusive", 128'(excl_err), 128'd0);
    check("stall_stability", 128'(stab_err), 128'd0);
    check("core_sb_empty", 128'(core_q.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
